dmem_arbiter: RTL and testbench

//  Shares the single synchronous data-memory port between the pipeline MEM stage and one auxiliary master (debug/DMA).

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared encodings for the data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

    // Owner of the read issued in a given cycle; the tag rides one cycle
    // behind the memory request so returning data reaches the right master.
    localparam logic [1:0] OWN_IDLE = 2'd0;
    localparam logic [1:0] OWN_PIPE = 2'd1;
    localparam logic [1:0] OWN_AUX  = 2'd2;

    localparam int DEF_MAX_WAIT = 4;
    localparam int DEF_CNT_W    = 4;

endpackage : dmem_arbiter_pkg

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares one synchronous data-memory port between the MEM
//                stage (fixed priority) and an auxiliary master, with a
//                starvation counter and a one-deep read-return tag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic [31:0] i_pipe_addr,
    input  logic [31:0] i_pipe_wdata,
    input  logic [3:0]  i_pipe_mask,
    input  logic        i_pipe_ren,
    input  logic        i_pipe_wen,
    output logic        o_pipe_stall,
    output logic [31:0] o_pipe_rdata,

    input  logic        i_aux_vld,
    input  logic [31:0] i_aux_addr,
    input  logic [31:0] i_aux_wdata,
    input  logic [3:0]  i_aux_mask,
    input  logic        i_aux_we,
    output logic        o_aux_rdy,
    output logic        o_aux_rvld,
    output logic [31:0] o_aux_rdata,

    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [CNT_W-1:0] C_MAX_WAIT = CNT_W'(MAX_WAIT);

    logic             w_pipe_req;
    logic             w_cnt_sat;
    logic             w_gnt_aux;
    logic [CNT_W-1:0] w_cnt_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [1:0]       w_rd_owner_d;
    logic [1:0]       r_rd_owner_q;

    assign w_pipe_req = i_pipe_ren | i_pipe_wen;
    assign w_cnt_sat  = (r_cnt_q == C_MAX_WAIT);
    // Aux wins when the pipeline is idle or has starved it for MAX_WAIT cycles.
    assign w_gnt_aux  = i_aux_vld && (!w_pipe_req || w_cnt_sat);

    assign o_aux_rdy    = w_gnt_aux;
    assign o_pipe_stall = w_pipe_req && w_gnt_aux;

    always_comb begin
        o_mem_addr  = i_pipe_addr;
        o_mem_wdata = i_pipe_wdata;
        o_mem_mask  = i_pipe_mask;
        o_mem_ren   = i_pipe_ren;
        o_mem_wen   = i_pipe_wen;
        if (w_gnt_aux) begin
            o_mem_addr  = i_aux_addr;
            o_mem_wdata = i_aux_wdata;
            o_mem_mask  = i_aux_mask;
            o_mem_ren   = !i_aux_we;
            o_mem_wen   = i_aux_we;
        end
    end

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (!i_aux_vld || w_gnt_aux) begin
            w_cnt_d = '0;
        end else if (!w_cnt_sat) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_comb begin
        w_rd_owner_d = OWN_IDLE;
        if (w_gnt_aux) begin
            if (!i_aux_we) begin
                w_rd_owner_d = OWN_AUX;
            end
        end else if (i_pipe_ren) begin
            w_rd_owner_d = OWN_PIPE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt_q      <= '0;
            r_rd_owner_q <= OWN_IDLE;
        end else begin
            r_cnt_q      <= w_cnt_d;
            r_rd_owner_q <= w_rd_owner_d;
        end
    end

    // Memory data is broadcast; only the aux side needs a qualifier.
    assign o_aux_rvld   = (r_rd_owner_q == OWN_AUX);
    assign o_aux_rdata  = i_mem_rdata;
    assign o_pipe_rdata = i_mem_rdata;

endmodule : dmem_arbiter

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a memory macro
//                model and a rule-level arbitration reference.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
    logic [3:0]  pipe_mask;
    logic        pipe_ren, pipe_wen, pipe_stall;
    logic        aux_vld, aux_we, aux_rdy, aux_rvld;
    logic [31:0] aux_addr, aux_wdata, aux_rdata;
    logic [3:0]  aux_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;
    logic        mem_ren, mem_wen;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [16];

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_pipe_addr(pipe_addr), .i_pipe_wdata(pipe_wdata), .i_pipe_mask(pipe_mask),
        .i_pipe_ren(pipe_ren), .i_pipe_wen(pipe_wen),
        .o_pipe_stall(pipe_stall), .o_pipe_rdata(pipe_rdata),
        .i_aux_vld(aux_vld), .i_aux_addr(aux_addr), .i_aux_wdata(aux_wdata),
        .i_aux_mask(aux_mask), .i_aux_we(aux_we),
        .o_aux_rdy(aux_rdy), .o_aux_rvld(aux_rvld), .o_aux_rdata(aux_rdata),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
        .o_mem_ren(mem_ren), .o_mem_wen(mem_wen), .i_mem_rdata(mem_rdata)
    );

    // Synchronous memory macro: read-old-data, byte-masked write.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_addr[5:2]];
        if (mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Aux must hold i_aux_vld until accepted.
    logic aux_pend_q = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) aux_pend_q <= 1'b0;
        else begin
            assert (!(aux_pend_q && !aux_vld)) else $error("aux protocol violation");
            aux_pend_q <= aux_vld && !aux_rdy;
        end
    end

    task automatic idle_inputs();
        pipe_addr = '0; pipe_wdata = '0; pipe_mask = '0; pipe_ren = 0; pipe_wen = 0;
        aux_vld = 0; aux_addr = '0; aux_wdata = '0; aux_mask = '0; aux_we = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        pipe_ren = 1; aux_vld = 1;
        #2;
        n_checks++;
        if (aux_rdy !== 1'b0 || pipe_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_grant: rdy=%b stall=%b required 0 0", aux_rdy, pipe_stall);
        end
        n_checks++;
        if (aux_rvld !== 1'b0 || dut.r_cnt_q !== 4'd0) begin
            n_fail++; $display("FAIL reset_state: rvld=%b cnt=%0d required 0 0", aux_rvld, dut.r_cnt_q);
        end
        idle_inputs();
        @(posedge clk); #1; rst_n = 1;
        next_cycle();
    endtask

    task automatic test_pipe_read();
        mem[0] = 32'h1234_5678;
        pipe_addr = 32'h100; pipe_ren = 1;
        @(negedge clk);
        n_checks++;
        if (mem_ren !== 1'b1 || mem_addr !== 32'h100 || pipe_stall !== 1'b0) begin
            n_fail++; $display("FAIL pipe_read_issue: ren=%b addr=%h stall=%b required 1 100 0", mem_ren, mem_addr, pipe_stall);
        end
        next_cycle();
        idle_inputs();
        n_checks++;
        if (pipe_rdata !== 32'h1234_5678 || aux_rvld !== 1'b0) begin
            n_fail++; $display("FAIL pipe_read_data: rdata=%h rvld=%b required 12345678 0", pipe_rdata, aux_rvld);
        end
        next_cycle();
    endtask

    task automatic test_aux_write();
        aux_vld = 1; aux_we = 1; aux_addr = 32'h200; aux_wdata = 32'hDEAD_BEEF; aux_mask = 4'hF;
        @(negedge clk);
        n_checks++;
        if (aux_rdy !== 1'b1 || mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_addr !== 32'h200
            || mem_wdata !== 32'hDEAD_BEEF || mem_mask !== 4'hF) begin
            n_fail++; $display("FAIL aux_write: rdy=%b wen=%b ren=%b addr=%h wdata=%h mask=%h required 1 1 0 200 deadbeef f",
                               aux_rdy, mem_wen, mem_ren, mem_addr, mem_wdata, mem_mask);
        end
        next_cycle();
        idle_inputs();
        n_checks++;
        if (dut.r_cnt_q !== 4'd0 || mem[0] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL aux_write_after: cnt=%0d mem=%h required 0 deadbeef", dut.r_cnt_q, mem[0]);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        int lost = 0;
        bit got  = 0;
        pipe_ren = 1; pipe_addr = 32'h4;
        aux_vld = 1; aux_we = 0; aux_addr = 32'h8;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (aux_rdy === 1'b1) begin
                got = 1;
                n_checks++;
                if (lost != MAX_WAIT || pipe_stall !== 1'b1) begin
                    n_fail++; $display("FAIL starvation_grant: lost=%0d stall=%b required %0d 1", lost, pipe_stall, MAX_WAIT);
                end
            end else lost++;
            next_cycle();
            if (got) aux_vld = 0;
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL starvation_timeout: aux never granted after %0d cycles required grant", lost);
        end
        n_checks++;
        if (dut.r_cnt_q !== 4'd0) begin
            n_fail++; $display("FAIL starvation_cnt: cnt=%0d required 0", dut.r_cnt_q);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        mem[4] = 32'hAAAA_0010; mem[8] = 32'hBBBB_0020;
        pipe_ren = 1; pipe_addr = 32'h10;
        next_cycle();
        idle_inputs();
        aux_vld = 1; aux_we = 0; aux_addr = 32'h20;
        @(negedge clk);
        n_checks++;
        if (pipe_rdata !== 32'hAAAA_0010 || aux_rvld !== 1'b0 || aux_rdy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_pipe: rdata=%h rvld=%b rdy=%b required aaaa0010 0 1", pipe_rdata, aux_rvld, aux_rdy);
        end
        next_cycle();
        idle_inputs();
        n_checks++;
        if (aux_rvld !== 1'b1 || aux_rdata !== 32'hBBBB_0020) begin
            n_fail++; $display("FAIL b2b_aux: rvld=%b rdata=%h required 1 bbbb0020", aux_rvld, aux_rdata);
        end
        next_cycle();
        n_checks++;
        if (aux_rvld !== 1'b0) begin
            n_fail++; $display("FAIL b2b_rvld_clear: rvld=%b required 0", aux_rvld);
        end
    endtask

    task automatic test_reset_inflight();
        bit seen = 0;
        aux_vld = 1; aux_we = 0; aux_addr = 32'h20;
        next_cycle();
        idle_inputs();
        rst_n = 0;
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (aux_rvld !== 1'b0) seen = 1;
        end
        @(posedge clk); #1; rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (aux_rvld !== 1'b0) seen = 1;
        end
        n_checks++;
        if (seen || dut.r_cnt_q !== 4'd0) begin
            n_fail++; $display("FAIL reset_inflight: rvld_seen=%b cnt=%0d required 0 0", seen, dut.r_cnt_q);
        end
        next_cycle();
    endtask

    task automatic test_pipe_wins();
        pipe_wen = 1; pipe_addr = 32'h30; pipe_wdata = 32'h0BAD_F00D; pipe_mask = 4'h3;
        aux_vld = 1; aux_we = 1; aux_addr = 32'h34; aux_wdata = 32'h1111_2222; aux_mask = 4'hF;
        @(negedge clk);
        n_checks++;
        if (aux_rdy !== 1'b0 || pipe_stall !== 1'b0 || mem_wen !== 1'b1 || mem_addr !== 32'h30
            || mem_wdata !== 32'h0BAD_F00D || mem_mask !== 4'h3) begin
            n_fail++; $display("FAIL pipe_wins: rdy=%b stall=%b wen=%b addr=%h wdata=%h mask=%h required 0 0 1 30 0badf00d 3",
                               aux_rdy, pipe_stall, mem_wen, mem_addr, mem_wdata, mem_mask);
        end
        next_cycle();
        n_checks++;
        if (dut.r_cnt_q !== 4'd1) begin
            n_fail++; $display("FAIL pipe_wins_cnt: cnt=%0d required 1", dut.r_cnt_q);
        end
        pipe_wen = 0;
        @(negedge clk);
        n_checks++;
        if (aux_rdy !== 1'b1 || mem_addr !== 32'h34) begin
            n_fail++; $display("FAIL pipe_idle_aux: rdy=%b addr=%h required 1 34", aux_rdy, mem_addr);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        int          m_cnt = 0;
        bit          stalled = 0;
        int          prev_own = 0;
        logic [31:0] prev_data = '0;
        bit          preq, egnt;
        int          own;
        logic [31:0] edata, eaddr;
        bit          eren, ewen;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        idle_inputs();
        for (int c = 0; c < 300; c++) begin
            if (!aux_vld && $urandom_range(0, 2) == 0) begin
                aux_vld = 1; aux_we = 1'($urandom_range(0, 1));
                aux_addr = {26'd0, 4'($urandom), 2'b00};
                aux_wdata = $urandom; aux_mask = 4'($urandom);
            end
            if (!stalled) begin
                int r = $urandom_range(0, 4);
                pipe_ren = (r == 1 || r == 2);
                pipe_wen = (r >= 3);
                pipe_addr = {26'd0, 4'($urandom), 2'b00};
                pipe_wdata = $urandom; pipe_mask = 4'($urandom);
            end
            @(negedge clk);
            preq = pipe_ren || pipe_wen;
            egnt = aux_vld && (!preq || m_cnt == MAX_WAIT);
            eaddr = egnt ? aux_addr : pipe_addr;
            eren  = egnt ? !aux_we : pipe_ren;
            ewen  = egnt ? aux_we : pipe_wen;
            own = 0; edata = '0;
            if (egnt && !aux_we) begin own = 2; edata = mem[aux_addr[5:2]]; end
            else if (!egnt && pipe_ren) begin own = 1; edata = mem[pipe_addr[5:2]]; end
            n_checks++;
            if (aux_rdy !== egnt || pipe_stall !== (preq && egnt)) begin
                n_fail++; $display("FAIL rand_grant c%0d: rdy=%b stall=%b required %b %b", c, aux_rdy, pipe_stall, egnt, preq && egnt);
            end
            n_checks++;
            if (mem_ren !== eren || mem_wen !== ewen || ((eren || ewen) && mem_addr !== eaddr)) begin
                n_fail++; $display("FAIL rand_mem c%0d: ren=%b wen=%b addr=%h required %b %b %h", c, mem_ren, mem_wen, mem_addr, eren, ewen, eaddr);
            end
            n_checks++;
            if (dut.r_cnt_q !== CNT_W'(m_cnt)) begin
                n_fail++; $display("FAIL rand_cnt c%0d: cnt=%0d required %0d", c, dut.r_cnt_q, m_cnt);
            end
            n_checks++;
            if (prev_own == 2 && (aux_rvld !== 1'b1 || aux_rdata !== prev_data)) begin
                n_fail++; $display("FAIL rand_aux_rd c%0d: rvld=%b rdata=%h required 1 %h", c, aux_rvld, aux_rdata, prev_data);
            end else if (prev_own == 1 && (aux_rvld !== 1'b0 || pipe_rdata !== prev_data)) begin
                n_fail++; $display("FAIL rand_pipe_rd c%0d: rvld=%b rdata=%h required 0 %h", c, aux_rvld, pipe_rdata, prev_data);
            end else if (prev_own == 0 && aux_rvld !== 1'b0) begin
                n_fail++; $display("FAIL rand_rvld_idle c%0d: rvld=%b required 0", c, aux_rvld);
            end
            next_cycle();
            if (!aux_vld || egnt) m_cnt = 0;
            else if (m_cnt < MAX_WAIT) m_cnt++;
            prev_own = own; prev_data = edata;
            stalled = preq && egnt;
            if (egnt) aux_vld = 0;
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem_rdata = '0;
        test_reset();
        test_pipe_read();
        test_aux_write();
        test_starvation();
        test_back_to_back();
        test_reset_inflight();
        test_pipe_wins();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule : tb_dmem_arbiter

`default_nettype wire
